hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage CPU (IF, ID, EX, MA, RW).
- Decodes the ID-stage instruction's source and destination registers and tracks in-flight writers in EX, MA and RW.
- Issues stall, bubble and flush controls to the pipeline registers.
- Sequences multi-cycle mul/div/mod in EX and supplies operand-forwarding selects to EX.

Parameters:
MUL_LAT, 3, EX cycles for mul (opcode 00010); legal range 1..15
DIV_LAT, 8, EX cycles for div (00011) and mod (00100); legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_instr  in  32  ID instruction: op[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14]
ex_taken  in  1  branch/ret/call in EX resolved taken this cycle
stall_front  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX instead of ID contents
flush_ifid  out  1  invalidate IF/ID contents
ex_hold  out  1  freeze ID/EX (EX instruction stays in EX)
bubble_ma  out  1  load NOP into EX/MA
fwd_a  out  2  EX operand A select: 00 regfile, 01 from MA, 10 from RW
fwd_b  out  2  EX operand B / store-data select, same encoding
mc_busy  out  1  multi-cycle op occupying EX

Behaviour:
- Clock, reset: one clock domain, clk. rst_n is asynchronous, active-low. Reset clears all shadow valids, state=RUN, counter=0.
- Outputs while reset is asserted: all 0.
- Reset mid-operation: an in-progress multi-cycle op is abandoned and no stall persists after reset.
- ID decode:
  - uses_s1: op in {0..7,10,11,12,14,15}; s1=rs1.
  - ret (10100): uses_s1=1, s1=15.
  - uses_s2: (I=0 and op in {0..12}) or op=15. s2=rs2, except st (01111), where s2=rd.
  - writes: op in {0..4,6..12,14} with dst=rd; or call (10011) with dst=15. cmp (00101) and nop (01101) never write.
  - All decode is gated by id_valid.
- Shadow pipeline: per stage EX/MA/RW hold {valid, writes, dst, is_ld, s1, s2, uses_s1, uses_s2}.
  - When not held, advance ID->EX->MA->RW each cycle.
  - Bubbles insert valid=0.
- State RUN:
  - Load-use: EX is_ld & writes, and ID uses a source equal to EX.dst. Response this cycle: stall_front=1, bubble_ex=1. Exactly one bubble, because MA-forward of a load is never used.
  - Multi-cycle entry: an instruction with op mul/div/mod is in EX and LAT>1. Load counter=LAT-1, go to MC_BUSY.
  - Branch: ex_taken=1 gives flush_ifid=1 and bubble_ex=1 for one cycle. ex_taken overrides load-use: that stall is dropped because the ID instruction is squashed.
- State MC_BUSY:
  - Asserted: mc_busy=1, ex_hold=1, stall_front=1, bubble_ma=1. The counter decrements each cycle.
  - Counter 1->0 transition: return to RUN. The op leaves EX on the next edge.
  - Total EX occupancy = LAT cycles exactly. LAT=1 never enters MC_BUSY.
  - ex_taken is ignored in MC_BUSY; branch ops are single-cycle.
  - A load-use hazard pending behind the op is re-evaluated in RUN.
- Forwarding (uses EX shadow sources; only valid & writes stages match):
  - fwd_a=01 if MA.dst==EX.s1 and MA is not a load.
  - Otherwise fwd_a=10 if RW.dst==EX.s1.
  - Otherwise 00. MA has priority over RW. fwd_b is the same using s2.
  - Unused sources give 00.
  - r0 is an ordinary register, so no zero-register exclusion.
- All outputs are combinational from registered state plus the ID decode. No extra latency.

Decomposition:
- Package hz_pkg holds:
  - opcode localparams (OP_ADD..OP_RET);
  - field bit positions;
  - RA_REG=4'd15;
  - fwd encodings FWD_RF/FWD_MA/FWD_RW;
  - state enum {RUN, MC_BUSY};
  - the decode functions uses_s1/uses_s2/writes_rd.
- Sub-module hz_fwd_sel computes one 2-bit forward select. It is instantiated twice, for A and B.

Test Plan:
- Reset: rst_n low mid MC_BUSY (counter=5) -> all outputs 0 immediately; after release, state=RUN and mc_busy=0.
- Load-use: ld r3 in EX, ID=add r4,r3,r5 -> exactly one cycle of stall_front=1 and bubble_ex=1. Next cycle, with add in EX and ld in RW -> fwd_a=10.
- Back-to-back ALU: add r1 in MA, sub r1 in RW, EX=or r2,r1,r1 -> fwd_a=01, fwd_b=01 (MA priority). With I=1 -> fwd_b=00.
- Divide, DIV_LAT=8: div enters EX -> mc_busy high for 7 cycles, EX occupancy 8 cycles, exactly 7 MA bubbles.
- Multiply, MUL_LAT=3: mul enters EX -> mc_busy high for 2 cycles.
- Branch vs load-use: ex_taken=1 while a load-use condition holds -> flush_ifid=1, bubble_ex=1, stall_front=0.
- ret/call: call in MA, EX=ret -> fwd_a=01 (reads r15). st r7 with rd=7 in EX and add r7 in RW -> fwd_b=10.

Source files
------------

// File: rtl/hz_pkg.sv
// Shared decode constants, shadow-stage record and operand/writer decode helpers
// for the 5-stage pipeline hazard scheduler.
package hz_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int IMM_BIT = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 18;
    localparam int RS2_HI = 17;
    localparam int RS2_LO = 14;

    localparam logic [3:0] RA_REG = 4'd15;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MA = 2'b01;
    localparam logic [1:0] FWD_RW = 2'b10;

    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic [3:0] dst;
        logic       is_ld;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       uses_s1;
        logic       uses_s2;
    } shadow_t;

    localparam shadow_t SHADOW_NOP = '0;

    function automatic logic uses_s1(input logic [4:0] op);
        return (op <= OP_OR) || (op inside {OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_ST, OP_RET});
    endfunction

    // st reads its data register through the second port
    function automatic logic uses_s2(input logic [4:0] op, input logic imm);
        return (!imm && (op <= OP_ASR)) || (op == OP_ST);
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return (op <= OP_MOD) || ((op >= OP_AND) && (op <= OP_ASR)) ||
               (op == OP_LD) || (op == OP_CALL);
    endfunction

    function automatic logic is_multicycle(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV, OP_MOD};
    endfunction

endpackage

// File: rtl/hz_fwd_sel.sv
// One EX operand forward select: youngest in-flight writer (MA) wins over RW.
module hz_fwd_sel
    import hz_pkg::*;
(
    input  logic       uses,
    input  logic [3:0] src,
    input  logic       ma_ok,
    input  logic [3:0] ma_dst,
    input  logic       rw_ok,
    input  logic [3:0] rw_dst,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (uses && ma_ok && (ma_dst == src)) begin
            sel = FWD_MA;
        end else if (uses && rw_ok && (rw_dst == src)) begin
            sel = FWD_RW;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Stall/bubble/flush and forwarding control for the IF-ID-EX-MA-RW pipeline.
//   state   | meaning
//   RUN     | normal issue; load-use and branch squash resolved here
//   MC_BUSY | mul/div/mod held in EX while cnt_q counts down to 1
module hazard_sched
    import hz_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_taken,
    output logic        stall_front,
    output logic        bubble_ex,
    output logic        flush_ifid,
    output logic        ex_hold,
    output logic        bubble_ma,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mc_busy
);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    shadow_t    ex_q, ex_d, ma_q, ma_d, rw_q, rw_d;
    shadow_t    id_dec;

    logic [4:0] id_op;
    logic [3:0] id_rd, id_rs1, id_rs2;
    logic       id_imm;
    logic       load_use;
    logic       mc_long;
    logic [3:0] mc_cnt_init;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       unused_bits;

    assign id_op  = id_instr[OP_HI:OP_LO];
    assign id_imm = id_instr[IMM_BIT];
    assign id_rd  = id_instr[RD_HI:RD_LO];
    assign id_rs1 = id_instr[RS1_HI:RS1_LO];
    assign id_rs2 = id_instr[RS2_HI:RS2_LO];
    assign unused_bits = ^{id_instr[13:0], rw_q.is_ld, rw_q.s1, rw_q.s2, rw_q.uses_s1, rw_q.uses_s2};

    always_comb begin
        id_dec = SHADOW_NOP;
        if (id_valid) begin
            id_dec.valid   = 1'b1;
            id_dec.uses_s1 = uses_s1(id_op);
            id_dec.s1      = (id_op == OP_RET) ? RA_REG : id_rs1;
            id_dec.uses_s2 = uses_s2(id_op, id_imm);
            id_dec.s2      = (id_op == OP_ST) ? id_rd : id_rs2;
            id_dec.writes  = writes_rd(id_op);
            id_dec.dst     = (id_op == OP_CALL) ? RA_REG : id_rd;
            id_dec.is_ld   = (id_op == OP_LD);
        end
    end

    assign load_use = ex_q.valid && ex_q.is_ld && ex_q.writes &&
                      ((id_dec.uses_s1 && (id_dec.s1 == ex_q.dst)) ||
                       (id_dec.uses_s2 && (id_dec.s2 == ex_q.dst)));

    assign mc_long     = (id_op == OP_MUL) ? (MUL_LAT > 1) : (DIV_LAT > 1);
    assign mc_cnt_init = (id_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'(DIV_LAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= SHADOW_NOP;
            ma_q    <= SHADOW_NOP;
            rw_q    <= SHADOW_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            ma_q    <= ma_d;
            rw_q    <= rw_d;
        end
    end

    // The busy count starts as the op is clocked into EX, so the op spends
    // LAT-1 cycles in MC_BUSY plus the final RUN cycle in EX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (id_valid && is_multicycle(id_op) && mc_long && !bubble_ex) begin
                    state_d = MC_BUSY;
                    cnt_d   = mc_cnt_init;
                end
            end
            MC_BUSY: begin
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_front = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        ex_hold     = 1'b0;
        bubble_ma   = 1'b0;
        mc_busy     = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (rst_n) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (state_q == MC_BUSY) begin
                mc_busy     = 1'b1;
                ex_hold     = 1'b1;
                stall_front = 1'b1;
                bubble_ma   = 1'b1;
            end else if (ex_taken) begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end else if (load_use) begin
                stall_front = 1'b1;
                bubble_ex   = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d = ex_q;
        ma_d = ma_q;
        rw_d = ma_q;
        if (ex_hold) begin
            ma_d = SHADOW_NOP;
        end else begin
            ma_d = ex_q;
            ex_d = bubble_ex ? SHADOW_NOP : id_dec;
        end
    end

    hz_fwd_sel u_fwd_a (
        .uses   (ex_q.uses_s1),
        .src    (ex_q.s1),
        .ma_ok  (ma_q.valid && ma_q.writes && !ma_q.is_ld),
        .ma_dst (ma_q.dst),
        .rw_ok  (rw_q.valid && rw_q.writes),
        .rw_dst (rw_q.dst),
        .sel    (fwd_a_sel)
    );

    hz_fwd_sel u_fwd_b (
        .uses   (ex_q.uses_s2),
        .src    (ex_q.s2),
        .ma_ok  (ma_q.valid && ma_q.writes && !ma_q.is_ld),
        .ma_dst (ma_q.dst),
        .rw_ok  (rw_q.valid && rw_q.writes),
        .rw_dst (rw_q.dst),
        .sel    (fwd_b_sel)
    );

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: the bench plays the pipeline, feeding one ID
// instruction per cycle and checking hand-computed control outputs.
module tb_hazard_sched;
    import hz_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_taken;
    logic        stall_front, bubble_ex, flush_ifid, ex_hold, bubble_ma, mc_busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [9:0]  outs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_LU   = 10'b1100000000;
    localparam logic [9:0] O_BR   = 10'b0110000000;
    localparam logic [9:0] O_MC   = 10'b1001110000;

    hazard_sched #(.MUL_LAT(3), .DIV_LAT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .ex_taken    (ex_taken),
        .stall_front (stall_front),
        .bubble_ex   (bubble_ex),
        .flush_ifid  (flush_ifid),
        .ex_hold     (ex_hold),
        .bubble_ma   (bubble_ma),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .mc_busy     (mc_busy)
    );

    assign outs = {stall_front, bubble_ex, flush_ifid, ex_hold, bubble_ma, mc_busy, fwd_a, fwd_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2);
        return {op, imm, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic tk);
        @(posedge clk);
        #1;
        id_valid = v;
        id_instr = ins;
        ex_taken = tk;
        #2;
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        id_valid = 1'b1;
        id_instr = mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0);
        ex_taken = 1'b1;
        #3;
        chk("reset_outs", 32'(outs), 32'(O_NONE));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        chk("post_reset_outs", 32'(outs), 32'(O_NONE));

        // load-use on rs1, one bubble, then RW forward of the load
        step(1'b1, mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0), 1'b0);
        chk("lu_ld_in_id", 32'(outs), 32'(O_NONE));
        step(1'b1, mk(OP_ADD, 1'b0, 4'd4, 4'd3, 4'd5), 1'b0);
        chk("lu_stall", 32'(outs), 32'(O_LU));
        step(1'b1, mk(OP_ADD, 1'b0, 4'd4, 4'd3, 4'd5), 1'b0);
        chk("lu_once", 32'(outs), 32'(O_NONE));
        step(1'b0, 32'd0, 1'b0);
        chk("lu_fwd", 32'(outs), 32'(10'b0000001000));

        // load-use through rs2, and no hazard when rs2 is an immediate
        idle3();
        step(1'b1, mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd4, 4'd5, 4'd3), 1'b0);
        chk("lu_s2", 32'(outs), 32'(O_LU));
        idle3();
        step(1'b1, mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b1, 4'd4, 4'd5, 4'd3), 1'b0);
        chk("lu_imm", 32'(outs), 32'(O_NONE));

        // back-to-back ALU writers: MA beats RW
        idle3();
        step(1'b1, mk(OP_SUB, 1'b0, 4'd1, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd1, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_OR,  1'b0, 4'd2, 4'd1, 4'd1), 1'b0);
        chk("alu_no_dep", 32'(outs), 32'(O_NONE));
        step(1'b0, 32'd0, 1'b0);
        chk("alu_fa", 32'(fwd_a), 32'(FWD_MA));
        chk("alu_fb", 32'(fwd_b), 32'(FWD_MA));
        idle3();
        step(1'b1, mk(OP_SUB, 1'b0, 4'd1, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd1, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_OR,  1'b1, 4'd2, 4'd1, 4'd1), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("alu_imm_fa", 32'(fwd_a), 32'(FWD_MA));
        chk("alu_imm_fb", 32'(fwd_b), 32'(FWD_RF));
        idle3();
        step(1'b1, mk(OP_SUB, 1'b0, 4'd1, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd9, 4'd6, 4'd7), 1'b0);
        step(1'b1, mk(OP_OR,  1'b0, 4'd2, 4'd1, 4'd1), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("alu_rw_fa", 32'(fwd_a), 32'(FWD_RW));
        chk("alu_rw_fb", 32'(fwd_b), 32'(FWD_RW));

        // cmp never writes its rd field
        idle3();
        step(1'b1, mk(OP_CMP, 1'b0, 4'd3, 4'd1, 4'd2), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd4, 4'd3, 4'd3), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("cmp_nowrite", 32'(outs), 32'(O_NONE));

        // divide: 7 busy cycles, 8 cycles in EX, then MA-forward of the result
        idle3();
        step(1'b1, mk(OP_DIV, 1'b0, 4'd2, 4'd3, 4'd4), 1'b0);
        chk("div_entry", 32'(outs), 32'(O_NONE));
        for (int i = 0; i < 7; i++) begin
            step(1'b1, mk(OP_ADD, 1'b0, 4'd5, 4'd2, 4'd6), 1'b0);
            chk($sformatf("div_busy%0d", i), 32'(outs), 32'(O_MC));
        end
        step(1'b1, mk(OP_ADD, 1'b0, 4'd5, 4'd2, 4'd6), 1'b0);
        chk("div_last", 32'(outs), 32'(O_NONE));
        step(1'b0, 32'd0, 1'b0);
        chk("div_leave", 32'(outs), 32'(10'b0000000100));

        // multiply: 2 busy cycles; a taken branch is ignored while busy
        idle3();
        step(1'b1, mk(OP_MUL, 1'b0, 4'd8, 4'd9, 4'd10), 1'b0);
        chk("mul_entry", 32'(outs), 32'(O_NONE));
        step(1'b0, 32'd0, 1'b0);
        chk("mul_busy0", 32'(outs), 32'(O_MC));
        step(1'b0, 32'd0, 1'b1);
        chk("mul_busy1_taken", 32'(outs), 32'(O_MC));
        step(1'b0, 32'd0, 1'b0);
        chk("mul_done", 32'(outs), 32'(O_NONE));

        // reset while a divide is busy with counter 5
        idle3();
        step(1'b1, mk(OP_DIV, 1'b0, 4'd2, 4'd3, 4'd4), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("rst_pre_cnt", 32'(dut.cnt_q), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'(O_NONE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        chk("rst_state", 32'(dut.state_q), 32'(RUN));
        chk("rst_release", 32'(outs), 32'(O_NONE));

        // taken branch overrides a pending load-use
        idle3();
        step(1'b1, mk(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0), 1'b0);
        step(1'b1, mk(OP_ADD, 1'b0, 4'd4, 4'd3, 4'd5), 1'b1);
        chk("br_vs_lu", 32'(outs), 32'(O_BR));
        step(1'b0, 32'd0, 1'b0);
        chk("br_after", 32'(outs), 32'(O_NONE));

        // call writes r15, ret reads r15
        idle3();
        step(1'b1, mk(OP_CALL, 1'b0, 4'd0, 4'd0, 4'd0), 1'b0);
        step(1'b1, mk(OP_RET,  1'b0, 4'd0, 4'd0, 4'd0), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("ret_fwd", 32'(outs), 32'(10'b0000000100));

        // store data comes from rd through operand B
        idle3();
        step(1'b1, mk(OP_ADD, 1'b0, 4'd7, 4'd1, 4'd2), 1'b0);
        step(1'b1, mk(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0), 1'b0);
        step(1'b1, mk(OP_ST,  1'b1, 4'd7, 4'd8, 4'd0), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("st_fwd", 32'(outs), 32'(10'b0000000010));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
